// File: rtl/mp_pool_engine_if.sv
// Signal bundle between mp_pool_engine, the dual-row BRAM controller and the
// pooled-pixel consumer.
interface mp_pool_engine_if #(parameter int WORD_W = 32);
    logic [8:0]        ifm_width;
    logic              stride1;
    logic              src_rows_ready;
    logic              src_rd;
    logic              src_rd_next;
    logic [WORD_W-1:0] src_dout;
    logic [WORD_W-1:0] src_dout_next;
    logic [WORD_W-1:0] pool_dout;
    logic              pool_valid;
    logic              pool_ready;
    logic              row_done;
    logic              busy;

    // Environment side: configuration, BRAM controller and write-back consumer.
    modport master (
        output ifm_width, stride1, src_rows_ready, src_dout, src_dout_next, pool_ready,
        input  src_rd, src_rd_next, pool_dout, pool_valid, row_done, busy
    );

    // Engine side.
    modport slave (
        input  ifm_width, stride1, src_rows_ready, src_dout, src_dout_next, pool_ready,
        output src_rd, src_rd_next, pool_dout, pool_valid, row_done, busy
    );
endinterface

// File: rtl/mp_pool_engine.sv
// 2x2 max-pool stage: vertical max of the even/odd row words, then horizontal
// max across column pairs (stride 2) or neighbouring columns with right-edge
// replicate (stride 1). Reads are issued only against reserved output credits
// so the output FIFO can never overflow.
module mp_pool_engine #(
    parameter int LANE_W      = 8,
    parameter int LANES       = 4,
    parameter int RD_LAT      = 1,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    mp_pool_engine_if.slave  bus
);
    localparam int WORD_W = LANE_W * LANES;
    localparam int PTR_W  = $clog2(OFIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OFIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, FLUSH = 2'd2} state_t;
    typedef struct packed {
        logic valid;
        logic emit;
        logic last;
    } tag_t;

    // Per-lane two's-complement max; ties pass operand a through.
    function automatic logic [WORD_W-1:0] lane_max(input logic [WORD_W-1:0] a,
                                                   input logic [WORD_W-1:0] b);
        logic [WORD_W-1:0] r;
        r = {WORD_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if ($signed(a[i*LANE_W +: LANE_W]) >= $signed(b[i*LANE_W +: LANE_W]))
                r[i*LANE_W +: LANE_W] = a[i*LANE_W +: LANE_W];
            else
                r[i*LANE_W +: LANE_W] = b[i*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    state_t              state_r;
    logic [8:0]          w_r;
    logic                s1_r;
    logic [8:0]          col_rd_r;
    logic                src_rd_r;
    logic                busy_r;
    logic                row_done_r;
    logic [CNT_W-1:0]    inflight_r;
    tag_t                tag_r [0:RD_LAT];
    tag_t                vtag_r;
    logic [WORD_W-1:0]   vmax_r;
    logic [WORD_W-1:0]   prev_r;
    logic                rep_pend_r;

    logic [WORD_W-1:0]   mem_r [0:OFIFO_DEPTH-1];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                pool_valid_r;
    logic [WORD_W-1:0]   pool_dout_r;

    logic                emit_s;
    logic                last_s;
    logic [CNT_W-1:0]    need_s;
    logic [CNT_W-1:0]    avail_s;
    logic                rd_go_s;
    logic                push_s;
    logic [WORD_W-1:0]   push_data_s;
    logic                pop_s;
    logic                pipe_empty_s;
    logic [CNT_W-1:0]    count_nxt_s;
    logic [PTR_W-1:0]    rd_ptr_nxt_s;
    logic [WORD_W-1:0]   head_nxt_s;

    // Read issue decision, H-stage output selection and FIFO next-state.
    always_comb begin
        emit_s       = 1'b0;
        last_s       = (col_rd_r == (w_r - 9'd1));
        push_s       = 1'b0;
        push_data_s  = {WORD_W{1'b0}};
        pipe_empty_s = !vtag_r.valid && !rep_pend_r;
        head_nxt_s   = {WORD_W{1'b0}};

        if (s1_r) begin
            emit_s = (col_rd_r != 9'd0);
        end else begin
            emit_s = col_rd_r[0];
        end
        // A stride-1 last column also owes the replicated right-edge output.
        need_s  = {{(CNT_W-1){1'b0}}, emit_s} + {{(CNT_W-1){1'b0}}, last_s & s1_r};
        avail_s = DEPTH_C - count_r - inflight_r;
        rd_go_s = (state_r == READ) && (col_rd_r < w_r) &&
                  (avail_s != {CNT_W{1'b0}}) && (avail_s >= need_s);

        for (int k = 0; k <= RD_LAT; k++) begin
            if (tag_r[k].valid) begin
                pipe_empty_s = 1'b0;
            end else begin
                pipe_empty_s = pipe_empty_s;
            end
        end

        if (rep_pend_r) begin
            push_s      = 1'b1;
            push_data_s = prev_r;
        end else if (vtag_r.valid && vtag_r.emit) begin
            push_s      = 1'b1;
            push_data_s = lane_max(vmax_r, prev_r);
        end else begin
            push_s      = 1'b0;
            push_data_s = {WORD_W{1'b0}};
        end

        pop_s        = pool_valid_r && bus.pool_ready;
        count_nxt_s  = count_r + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};
        rd_ptr_nxt_s = rd_ptr_r + {{(PTR_W-1){1'b0}}, pop_s};
        // Into an empty (or draining-to-empty) FIFO the new word becomes the head directly.
        if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = push_data_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Row FSM, credit accounting and the read/V/H pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            w_r        <= 9'd0;
            s1_r       <= 1'b0;
            col_rd_r   <= 9'd0;
            src_rd_r   <= 1'b0;
            busy_r     <= 1'b0;
            row_done_r <= 1'b0;
            inflight_r <= {CNT_W{1'b0}};
            for (int k = 0; k <= RD_LAT; k++) tag_r[k] <= '0;
            vtag_r     <= '0;
            vmax_r     <= {WORD_W{1'b0}};
            prev_r     <= {WORD_W{1'b0}};
            rep_pend_r <= 1'b0;
        end else begin
            tag_r[0].valid <= rd_go_s;
            tag_r[0].emit  <= rd_go_s & emit_s;
            tag_r[0].last  <= rd_go_s & last_s;
            for (int k = 1; k <= RD_LAT; k++) tag_r[k] <= tag_r[k-1];
            vtag_r <= tag_r[RD_LAT];
            if (tag_r[RD_LAT].valid) vmax_r <= lane_max(bus.src_dout, bus.src_dout_next);
            if (vtag_r.valid) prev_r <= vmax_r;
            rep_pend_r <= vtag_r.valid && vtag_r.last && s1_r;
            inflight_r <= inflight_r + (rd_go_s ? need_s : {CNT_W{1'b0}})
                          - {{(CNT_W-1){1'b0}}, push_s};
            src_rd_r   <= rd_go_s;
            row_done_r <= 1'b0;

            case (state_r)
                IDLE: begin
                    if (bus.src_rows_ready) begin
                        state_r  <= READ;
                        w_r      <= bus.ifm_width;
                        s1_r     <= bus.stride1;
                        col_rd_r <= 9'd0;
                        busy_r   <= 1'b1;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                READ: begin
                    // col_rd >= W only for an illegal zero width; leave the row anyway.
                    if (col_rd_r >= w_r) begin
                        state_r <= FLUSH;
                    end else if (rd_go_s) begin
                        col_rd_r <= col_rd_r + 9'd1;
                        if (last_s) state_r <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pipe_empty_s) begin
                        state_r    <= IDLE;
                        row_done_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output FIFO with a registered head word and registered valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < OFIFO_DEPTH; k++) mem_r[k] <= {WORD_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            pool_valid_r <= 1'b0;
            pool_dout_r  <= {WORD_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            rd_ptr_r     <= rd_ptr_nxt_s;
            count_r      <= count_nxt_s;
            pool_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            pool_dout_r  <= (count_nxt_s != {CNT_W{1'b0}}) ? head_nxt_s : {WORD_W{1'b0}};
        end
    end

    assign bus.src_rd      = src_rd_r;
    assign bus.src_rd_next = src_rd_r;
    assign bus.pool_dout   = pool_dout_r;
    assign bus.pool_valid  = pool_valid_r;
    assign bus.row_done    = row_done_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_mp_pool_engine.sv
// Directed bench for mp_pool_engine: BRAM read model, output collector and a
// linear sequence of row scenarios with hand-computed pooled words.
module tb_mp_pool_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mp_pool_engine_if bus ();

    mp_pool_engine #(.LANE_W(8), .LANES(4), .RD_LAT(1), .OFIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] even_mem [0:31];
    logic [31:0] odd_mem  [0:31];
    logic [8:0]  bram_addr;
    logic [31:0] src_dout_m;
    logic [31:0] src_dout_next_m;

    assign bus.src_dout      = src_dout_m;
    assign bus.src_dout_next = src_dout_next_m;

    // One-cycle-latency BRAM pair; the column address restarts whenever the engine is idle.
    always @(posedge clk) begin
        if (!bus.busy) bram_addr <= 9'd0;
        else if (bus.src_rd) bram_addr <= bram_addr + 9'd1;
        if (bus.src_rd) begin
            src_dout_m      <= even_mem[bram_addr[4:0]];
            src_dout_next_m <= odd_mem[bram_addr[4:0]];
        end
    end

    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int rdn_err = 0;
    int last_hs_cyc = 0;
    int done_cyc = 0;
    logic [31:0] got_q [$];

    // Collect accepted outputs and count strobes/pulses.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.src_rd) rd_cnt <= rd_cnt + 1;
        if (bus.src_rd !== bus.src_rd_next) rdn_err <= rdn_err + 1;
        if (bus.pool_valid && bus.pool_ready) begin
            got_q.push_back(bus.pool_dout);
            last_hs_cyc <= cyc;
        end
        if (bus.row_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_row(input logic [8:0] w, input logic s1);
        @(negedge clk);
        bus.ifm_width      = w;
        bus.stride1        = s1;
        bus.src_rows_ready = 1'b1;
        @(negedge clk);
        bus.src_rows_ready = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.row_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int base;
        int rd0;
        int dn0;
        logic [31:0] hold;

        rst = 1'b1;
        bus.src_rows_ready = 1'b0;
        bus.pool_ready     = 1'b0;
        bus.ifm_width      = 9'd0;
        bus.stride1        = 1'b0;
        for (int c = 0; c < 32; c++) begin
            even_mem[c] = 32'h0;
            odd_mem[c]  = 32'h0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy",   {31'd0, bus.busy},       32'd0);
        chk("rst_src_rd", {31'd0, bus.src_rd},     32'd0);
        chk("rst_valid",  {31'd0, bus.pool_valid}, 32'd0);
        chk("rst_done",   {31'd0, bus.row_done},   32'd0);
        chk("rst_dout",   bus.pool_dout,           32'h0);
        rst = 1'b0;

        // Stride 2, W=4, consumer always ready.
        even_mem[0] = 32'h01020304; even_mem[1] = 32'h05FF0708;
        even_mem[2] = 32'h10203040; even_mem[3] = 32'h7F808182;
        for (int c = 0; c < 4; c++) odd_mem[c] = 32'h02020202;
        bus.pool_ready = 1'b1;
        base = got_q.size(); rd0 = rd_cnt; dn0 = done_cnt;
        start_row(9'd4, 1'b0);
        wait_done("s2w4_timeout", 100);
        repeat (2) @(negedge clk);
        chk("s2w4_count", got_q.size() - base, 32'd2);
        chk("s2w4_out0",  got_q[base],         32'h05020708);
        chk("s2w4_out1",  got_q[base+1],       32'h7F203040);
        chk("s2w4_done",  done_cnt - dn0,      32'd1);
        chk("s2w4_rd",    rd_cnt - rd0,        32'd4);
        chk("s2w4_done_lag", done_cyc - last_hs_cyc, 32'd1);

        // Stride 1, W=3: odd row at the most negative value so vmax = even word.
        even_mem[0] = 32'h01010101; even_mem[1] = 32'h03030303; even_mem[2] = 32'h02020202;
        for (int c = 0; c < 4; c++) odd_mem[c] = 32'h80808080;
        base = got_q.size(); rd0 = rd_cnt; dn0 = done_cnt;
        start_row(9'd3, 1'b1);
        wait_done("s1w3_timeout", 100);
        repeat (2) @(negedge clk);
        chk("s1w3_count", got_q.size() - base, 32'd3);
        chk("s1w3_out0",  got_q[base],         32'h03030303);
        chk("s1w3_out1",  got_q[base+1],       32'h03030303);
        chk("s1w3_out2",  got_q[base+2],       32'h02020202);
        chk("s1w3_done",  done_cnt - dn0,      32'd1);
        chk("s1w3_rd",    rd_cnt - rd0,        32'd3);

        // Stride 2, W=5: last column read and dropped.
        for (int c = 0; c < 5; c++) even_mem[c] = {4{8'(8'h11 * (c + 1))}};
        base = got_q.size(); rd0 = rd_cnt; dn0 = done_cnt;
        start_row(9'd5, 1'b0);
        wait_done("s2w5_timeout", 100);
        repeat (2) @(negedge clk);
        chk("s2w5_count", got_q.size() - base, 32'd2);
        chk("s2w5_out0",  got_q[base],         32'h22222222);
        chk("s2w5_out1",  got_q[base+1],       32'h44444444);
        chk("s2w5_rd",    rd_cnt - rd0,        32'd5);
        chk("s2w5_done",  done_cnt - dn0,      32'd1);

        // Backpressure: stride 2, W=16, consumer stalled.
        for (int c = 0; c < 16; c++) even_mem[c] = {4{8'(c)}};
        bus.pool_ready = 1'b0;
        base = got_q.size(); rd0 = rd_cnt; dn0 = done_cnt;
        start_row(9'd16, 1'b0);
        repeat (30) @(negedge clk);
        chk("bp_rd_stall", rd_cnt - rd0, 32'd8);
        chk("bp_valid",    {31'd0, bus.pool_valid}, 32'd1);
        hold = bus.pool_dout;
        chk("bp_head",     hold, 32'h01010101);
        repeat (5) @(negedge clk);
        chk("bp_stable",   bus.pool_dout, hold);
        chk("bp_rd_still", rd_cnt - rd0, 32'd8);
        bus.pool_ready = 1'b1;
        wait_done("bp_timeout", 300);
        repeat (2) @(negedge clk);
        chk("bp_count", got_q.size() - base, 32'd8);
        for (int k = 0; k < 8; k++) chk("bp_out", got_q[base+k], {4{8'(2*k + 1)}});
        chk("bp_rd_total", rd_cnt - rd0, 32'd16);

        // Reset in the middle of a row.
        rd0 = rd_cnt;
        start_row(9'd16, 1'b0);
        for (int i = 0; i < 60; i++) begin
            if (rd_cnt - rd0 >= 6) break;
            @(negedge clk);
        end
        chk("mid_reached", {31'd0, (rd_cnt - rd0 >= 6)}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_busy",   {31'd0, bus.busy},       32'd0);
        chk("mid_src_rd", {31'd0, bus.src_rd},     32'd0);
        chk("mid_valid",  {31'd0, bus.pool_valid}, 32'd0);
        rst = 1'b0;
        even_mem[0] = 32'h01020304; even_mem[1] = 32'h05FF0708;
        even_mem[2] = 32'h10203040; even_mem[3] = 32'h7F808182;
        for (int c = 0; c < 4; c++) odd_mem[c] = 32'h02020202;
        base = got_q.size(); dn0 = done_cnt;
        start_row(9'd4, 1'b0);
        wait_done("post_rst_timeout", 100);
        repeat (2) @(negedge clk);
        chk("post_rst_count", got_q.size() - base, 32'd2);
        chk("post_rst_out0",  got_q[base],         32'h05020708);
        chk("post_rst_out1",  got_q[base+1],       32'h7F203040);
        chk("post_rst_done",  done_cnt - dn0,      32'd1);

        // Back-to-back rows with signed lanes (0x80 vs 0xFF -> 0xFF).
        even_mem[0] = 32'h80FF7F00; odd_mem[0] = 32'hFF80017F;
        even_mem[1] = 32'h80808080; odd_mem[1] = 32'h80808080;
        base = got_q.size(); rd0 = rd_cnt; dn0 = done_cnt;
        @(negedge clk);
        bus.ifm_width      = 9'd2;
        bus.stride1        = 1'b0;
        bus.src_rows_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            wait_done("b2b_timeout", 100);
            chk("b2b_idle", {31'd0, bus.busy}, 32'd0);
            @(negedge clk);
            if (r < 2) chk("b2b_restart", {31'd0, bus.busy}, 32'd1);
            if (r == 1) bus.src_rows_ready = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("b2b_end_idle", {31'd0, bus.busy}, 32'd0);
        chk("b2b_done",  done_cnt - dn0,      32'd3);
        chk("b2b_rd",    rd_cnt - rd0,        32'd6);
        chk("b2b_count", got_q.size() - base, 32'd3);
        for (int k = 0; k < 3; k++) chk("b2b_out", got_q[base+k], 32'hFFFF7F7F);

        chk("rd_next_eq", rdn_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mp_pool_engine.md
Name: mp_pool_engine

Overview:
- 2x2 max-pool compute stage directly downstream of the dual-row maxpool BRAM controller.
- Reads one pixel word per cycle from the even-row and odd-row BRAMs in lockstep. Takes the vertical max, then the horizontal max across a column pair.
- Emits pooled pixel words on a valid/ready stream toward the output write-back.
- Supports stride 2 (all YOLOv2 pool layers except the last) and stride 1 with right-edge replicate (13x13 final pool).

Parameters:
- LANE_W, 8, bit width of one signed channel value
- LANES, 4, channel lanes per 32-bit pixel word (LANE_W*LANES = 32)
- RD_LAT, 1, source BRAM read latency in cycles
- OFIFO_DEPTH, 4, output FIFO entries (power of 2, >= RD_LAT+3)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifm_width  in  9  pixels per row, valid range 2..416; sampled on row start
- stride1  in  1  0 = 2x2 stride 2; 1 = 2x2 stride 1; sampled on row start
- src_rows_ready  in  1  both row BRAMs hold a complete row (controller dout_full)
- src_rd  out  1  read strobe, even row (controller dout_valid)
- src_rd_next  out  1  read strobe, odd row (controller dout_valid_next); always equal to src_rd
- src_dout  in  32  even-row pixel word, RD_LAT after src_rd
- src_dout_next  in  32  odd-row pixel word, RD_LAT after src_rd
- pool_dout  out  32  pooled pixel word
- pool_valid  out  1  pool_dout valid
- pool_ready  in  1  consumer accepts when pool_valid & pool_ready
- row_done  out  1  one-cycle pulse after the last output of a row is written into the FIFO
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at a clk edge) applies from any state, including mid-row. It clears all of the following:
  - FSM goes to IDLE.
  - Counters, credits, pipeline valids and FIFO pointers are cleared.
  - Outputs go to 0: src_rd, src_rd_next, pool_valid, row_done, busy, pool_dout.
  - In-flight BRAM data is discarded.
- FSM states:
  - IDLE -> READ when src_rows_ready=1. On that edge, latch W=ifm_width and S1=stride1, and clear col_rd and col_out.
  - READ: assert src_rd when credits >= 1 and col_rd < W. Each read increments col_rd. On the read with col_rd = W-1 -> FLUSH.
  - FLUSH: no reads. When the pipeline is empty and the final output is written to the FIFO, pulse row_done and go to IDLE.
  - Staying in IDLE for one cycle guarantees src_rows_ready is re-evaluated after the controller swaps BRAMs.
- Pipeline, for a read at cycle t:
  - Source data valid at t+RD_LAT.
  - V-stage registers vmax = per-lane signed max(src_dout, src_dout_next) at t+RD_LAT+1.
  - H-stage computes the per-lane signed max of the current vmax and the held previous vmax. The result is written to the FIFO at t+RD_LAT+2.
  - pool_valid rises the following cycle when the FIFO was empty.
- Column rules:
  - Stride 2: an output is produced on odd column index c (pair c-1,c). Output count = floor(W/2). For odd W the last column is read and dropped.
  - Stride 1: the output for column c = max(vmax[c], vmax[c+1]), produced when column c+1 arrives. For c = W-1 the output = vmax[W-1] (replicate), produced in FLUSH. Output count = W.
- Credit flow control:
  - credits = OFIFO_DEPTH - fifo_count - outputs_in_flight.
  - Each read that will produce an output reserves one credit at issue. Reads that produce no output (stride-2 even columns, stride-1 column 0, the dropped odd column) reserve none.
  - Reads stall, never drop. The FIFO never overflows.
  - With pool_ready held low, reading stops once the FIFO is full.
- Output FIFO:
  - pool_dout is the FIFO head; it is held stable while pool_valid=1 and pool_ready=0.
  - A simultaneous push and pop on a full FIFO is legal: count is unchanged.
- Arithmetic: the lane compare is two's-complement signed. Equal values pass through. No saturation is needed.
- W < 2 is illegal. Behaviour is unspecified, but the FSM must still return to IDLE.

Test Plan:
- Stride 2, W=4, pool_ready=1:
  - Even row lanes 0x01020304, 0x05FF0708, 0x10203040, 0x7F808182; odd row all 0x02020202.
  - Required outputs: 0x05020708, then 0x7F203040.
  - row_done pulses once, 1 cycle after the second FIFO write.
- Stride 1, W=3, column vmax words A=0x01010101, B=0x03030303, C=0x02020202:
  - Required outputs: 0x03030303, 0x03030303, 0x02020202 (C replicated).
- Stride 2, W=5:
  - Required: 2 outputs and 5 src_rd pulses. The 5th column is never emitted.
- Backpressure, stride 2, W=16, pool_ready=0:
  - Required: src_rd stops after 8 reads (4 FIFO entries).
  - Then release pool_ready: all 8 outputs arrive in order with none lost; pool_dout is stable while stalled.
- Assert rst at mid-row column 6:
  - Next cycle: busy=0, src_rd=0, pool_valid=0.
  - A following full row with src_rows_ready=1 produces correct fresh results.
- Back-to-back rows with src_rows_ready high continuously:
  - Required: exactly one IDLE cycle between rows; row_done count equals row count.
  - Signed check: lanes 0x80 vs 0xFF must yield 0xFF.
